// File: rtl/max_pool_window_feeder.sv
// Raster pixel stream to 3-row column stream for the max-pool column datapath.
// Latency: 1 cycle accept->col_en_o, 2 cycles accept->pool_v_o, 1 cycle accept->frame_done_o.
// Backpressure: none internally; pix_ready_o is low only during reset, and downstream cannot stall.
module max_pool_window_feeder #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int POOL_W = 3,
    parameter int PIX_W  = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               pix_v_i,
    input  logic [PIX_W-1:0]                   pix_i,
    output logic                               pix_ready_o,
    output logic [2:0][PIX_W-1:0]              col_o,
    output logic                               col_en_o,
    output logic                               col_init_o,
    output logic                               pool_v_o,
    output logic [$clog2(IMG_W/POOL_W)-1:0]    pool_x_o,
    output logic                               frame_done_o
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NW = IMG_W / POOL_W;
    localparam int XW = $clog2(NW);
    localparam int SW = (POOL_W > 1) ? $clog2(POOL_W) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(POOL_W - 1);
    localparam logic [XW:0]   WIN_LIM  = (XW+1)'(NW);
    localparam logic [RW-1:0] GRP_LIM  = RW'(IMG_H / 3);

    // Position counters: column, row, row phase, column-within-window, window index, row group
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    phase_q, phase_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [XW:0]   wx_q, wx_d;
    logic [RW-1:0] grp_q, grp_d;

    logic                 ready_q;
    logic [2:0][PIX_W-1:0] col_q_o;
    logic                 col_en_q, col_init_q;
    logic                 last_q;
    logic [XW-1:0]        last_x_q;
    logic                 pool_v_q;
    logic [XW-1:0]        pool_x_q;
    logic                 done_q;

    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];

    logic accept;
    logic in_win;   // pixel lies inside a complete pooling window (not in a discarded tail)
    logic live;     // accepted phase-2 pixel that completes a column

    assign accept = pix_v_i & ready_q;
    assign in_win = (wx_q < WIN_LIM) && (grp_q < GRP_LIM);
    assign live   = accept && (phase_q == 2'd2) && in_win;

    // Counter next-state: advance only on accepted pixels, wrapping at row and frame ends
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        phase_d = phase_q;
        sub_d   = sub_q;
        wx_d    = wx_q;
        grp_d   = grp_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                sub_d = '0;
                wx_d  = '0;
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    phase_d = '0;
                    grp_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (phase_q == 2'd2) begin
                        phase_d = '0;
                        grp_d   = grp_q + 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    wx_d  = wx_q + 1'b1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
        end
    end

    // State and output registers; reset drops any column or pool result in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q      <= '0;
            row_q      <= '0;
            phase_q    <= '0;
            sub_q      <= '0;
            wx_q       <= '0;
            grp_q      <= '0;
            ready_q    <= 1'b0;
            col_q_o    <= '0;
            col_en_q   <= 1'b0;
            col_init_q <= 1'b0;
            last_q     <= 1'b0;
            last_x_q   <= '0;
            pool_v_q   <= 1'b0;
            pool_x_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            phase_q    <= phase_d;
            sub_q      <= sub_d;
            wx_q       <= wx_d;
            grp_q      <= grp_d;
            ready_q    <= 1'b1;
            col_en_q   <= live;
            col_init_q <= live && (sub_q == '0);
            if (live) begin
                col_q_o <= {pix_i, lb1_q[col_q], lb0_q[col_q]};
            end
            last_q   <= live && (sub_q == SUB_LAST);
            last_x_q <= wx_q[XW-1:0];
            pool_v_q <= last_q;
            if (last_q) begin
                pool_x_q <= last_x_q;
            end
            done_q <= accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
        end
    end

    // Line buffers hold rows 3k and 3k+1 until the third row of the group arrives
    always_ff @(posedge clk_i) begin
        if (accept && in_win && (phase_q == 2'd0)) begin
            lb0_q[col_q] <= pix_i;
        end
        if (accept && in_win && (phase_q == 2'd1)) begin
            lb1_q[col_q] <= pix_i;
        end
    end

    assign pix_ready_o  = ready_q;
    assign col_o        = col_q_o;
    assign col_en_o     = col_en_q;
    assign col_init_o   = col_init_q;
    assign pool_v_o     = pool_v_q;
    assign pool_x_o     = pool_x_q;
    assign frame_done_o = done_q;
endmodule

// File: tb/tb_max_pool_window_feeder.sv
// Directed bench for max_pool_window_feeder with a reference position model and a
// behavioural running-max consumer standing in for the downstream pooling stage.
module tb_max_pool_window_feeder;
    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            pix_v_i;
    logic [7:0]      pix_i;
    logic            pix_ready_o;
    logic [2:0][7:0] col_o;
    logic            col_en_o;
    logic            col_init_o;
    logic            pool_v_o;
    logic [3:0]      pool_x_o;
    logic            frame_done_o;

    max_pool_window_feeder dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .pix_v_i      (pix_v_i),
        .pix_i        (pix_i),
        .pix_ready_o  (pix_ready_o),
        .col_o        (col_o),
        .col_en_o     (col_en_o),
        .col_init_o   (col_init_o),
        .pool_v_o     (pool_v_o),
        .pool_x_o     (pool_x_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] img [28][28];
    int   evals = 0;
    int   fails = 0;
    int   r, c;
    bit   rdy_exp;
    bit   pend_last;
    int   pend_x, pend_g, held_x;
    int   rm;
    int   pools, dones;
    bit   seen_done;
    bit   first_seen;
    logic [23:0] first_col;
    int   first_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winmax(input int g, input int x);
        int m = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (int'(img[g*3+i][x*3+j]) > m) m = int'(img[g*3+i][x*3+j]);
        return m;
    endfunction

    function automatic int max3(input int a, input int b, input int d);
        int m = a;
        if (b > m) m = b;
        if (d > m) m = d;
        return m;
    endfunction

    // One clock: drive, clock, then compare every output against the model
    task automatic step(input bit v);
        bit acc, e_en, e_done;
        pix_v_i = v;
        pix_i   = v ? img[r][c] : 8'($urandom);
        acc     = v && rdy_exp && !reset_i;
        @(posedge clk_i);
        #1;
        if (reset_i) begin
            chk("rst_ready", 32'(pix_ready_o), 32'd0);
            chk("rst_col_en", 32'(col_en_o), 32'd0);
            chk("rst_col_init", 32'(col_init_o), 32'd0);
            chk("rst_pool_v", 32'(pool_v_o), 32'd0);
            chk("rst_pool_x", 32'(pool_x_o), 32'd0);
            chk("rst_done", 32'(frame_done_o), 32'd0);
            r = 0; c = 0; pend_last = 0; held_x = 0; rdy_exp = 0;
        end else begin
            e_en   = acc && (r % 3 == 2) && (c < 27) && (r < 27);
            e_done = acc && (r == 27) && (c == 27);
            chk("ready", 32'(pix_ready_o), 32'd1);
            chk("col_en", 32'(col_en_o), 32'(e_en));
            if (e_en) begin
                chk("col", 32'(col_o), {8'd0, img[r][c], img[r-1][c], img[r-2][c]});
                chk("col_init", 32'(col_init_o), 32'(c % 3 == 0));
            end
            chk("pool_v", 32'(pool_v_o), 32'(pend_last));
            if (pend_last) held_x = pend_x;
            chk("pool_x", 32'(pool_x_o), 32'(held_x));
            if (pend_last && pool_v_o) begin
                pools++;
                chk("pool_max", 32'(rm), 32'(winmax(pend_g, pend_x)));
                if (pend_g == 0 && pend_x == 0) first_max = rm;
            end
            if (col_en_o) begin
                if (col_init_o) rm = max3(col_o[0], col_o[1], col_o[2]);
                else rm = max3(rm, max3(col_o[0], col_o[1], col_o[2]), 0);
                if (!first_seen) begin
                    first_col  = col_o;
                    first_seen = 1;
                end
            end
            chk("frame_done", 32'(frame_done_o), 32'(e_done));
            if (frame_done_o) begin
                dones++;
                seen_done = 1;
            end
            pend_last = e_en && (c % 3 == 2);
            pend_x    = c / 3;
            pend_g    = r / 3;
            if (acc) begin
                if (c == 27) begin
                    c = 0;
                    r = (r == 27) ? 0 : r + 1;
                end else begin
                    c++;
                end
            end
            rdy_exp = 1;
        end
    endtask

    task automatic run_frame(input bit gaps);
        pools = 0; dones = 0; seen_done = 0; first_seen = 0;
        for (int n = 0; n < 4000 && !seen_done; n++)
            step(gaps ? 1'($urandom_range(0, 1)) : 1'b1);
        step(1'b0);
        step(1'b0);
        chk("frame_done_count", 32'(dones), 32'd1);
        chk("pool_count", 32'(pools), 32'd81);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 28; i++)
            for (int j = 0; j < 28; j++)
                img[i][j] = 8'((i * 28 + j) & 8'hFF);
    endtask

    task automatic fill_tail();
        for (int i = 0; i < 28; i++)
            for (int j = 0; j < 28; j++)
                img[i][j] = (i == 27 || j == 27) ? 8'hFF : 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        r = 0; c = 0; rdy_exp = 0; pend_last = 0; pend_x = 0; pend_g = 0;
        held_x = 0; rm = 0; first_max = -1; first_col = '0;
        fill_ramp();
        reset_i = 1'b1;
        pix_v_i = 1'b0;
        pix_i   = 8'h00;
        step(1'b0);
        step(1'b0);
        reset_i = 1'b0;
        step(1'b0);

        // Ramp frame, continuous valid
        run_frame(1'b0);
        chk("first_col", 32'(first_col), 32'h0038_1C00);
        chk("win00_max", 32'(first_max), 32'd58);

        // Tail pixels saturated, everything pooled must stay 0
        fill_tail();
        run_frame(1'b0);

        // Ramp frame with random valid gaps
        fill_ramp();
        first_max = -1;
        run_frame(1'b1);
        chk("gap_first_col", 32'(first_col), 32'h0038_1C00);
        chk("gap_win00_max", 32'(first_max), 32'd58);

        // Reset mid-frame at pixel (4,10), then a fresh frame
        for (int n = 0; n < 200 && !(r == 4 && c == 10); n++) step(1'b1);
        chk("reached_4_10", 32'(r * 28 + c), 32'(4 * 28 + 10));
        reset_i = 1'b1;
        step(1'b1);
        step(1'b1);
        reset_i = 1'b0;
        step(1'b0);
        first_max = -1;
        run_frame(1'b0);
        chk("rst_first_col", 32'(first_col), 32'h0038_1C00);
        chk("rst_win00_max", 32'(first_max), 32'd58);

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end
endmodule
